register_file: RTL and testbench
================================

Name: register_file

Overview:
- Small multi-ported register file for the 16-bit CPU datapath: 4 general registers × 16 bits.
- Two independent combinational read ports feed the ALU operands.
- One synchronous write port is fed from the writeback stage.
- Storage array is named reg_file (index 0..DEPTH-1) so benches can preload or inspect it hierarchically.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- ADDR_WIDTH, 2, address width; DEPTH = 2**ADDR_WIDTH = 4 registers.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- write_en  input  1  write enable, sampled at rising clk.
- read_en  input  1  read enable for both read ports (combinational gate).
- write_adr  input  ADDR_WIDTH  destination register index.
- read_adr1  input  ADDR_WIDTH  read port 1 register index.
- read_adr2  input  ADDR_WIDTH  read port 2 register index.
- write_data  input  DATA_WIDTH  data to write.
- read_data1  output  DATA_WIDTH  contents of reg_file[read_adr1] when read_en=1.
- read_data2  output  DATA_WIDTH  contents of reg_file[read_adr2] when read_en=1.

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Storage: array reg_file[0:DEPTH-1] of DATA_WIDTH-bit regs; no hardwired-zero register, all four writable.
- Reset:
  - Asserting reset immediately (no clock needed) clears all reg_file entries to 0.
  - Entries are held at 0 while reset is high.
  - Writes are ignored while reset is high; reset has priority over write_en.
- Write:
  - On rising clk with reset=0 and write_en=1, reg_file[write_adr] <= write_data.
  - Single-cycle latency; other entries unchanged.
  - write_en=0: no change.
- Read:
  - Purely combinational, zero latency.
  - read_dataN = read_en ? reg_file[read_adrN] : 0.
  - Outputs track address and storage changes within the same delta.
- read_en=0 forces both outputs to 0; it has no effect on writes. write_en and read_en are independent and may both be high.
- Same-address read during write: read port returns the old value until the write edge, then the new value (no write-through bypass).
- Both read ports may address the same register; both return the same value.
- Reset asserted mid-operation: outputs drop to 0 (if read_en=1, they show cleared contents) asynchronously.
- Unknown/X addresses: no requirement beyond simulator semantics; addresses are always in range by width.

Test Plan:
- Backdoor-preload reg_file = {CCCC, AAAA, F0F0, 8E38}, reset=0, read_en=1, read_adr1=0, read_adr2=1 -> read_data1=16'hCCCC, read_data2=16'hAAAA with no clock edge needed.
- Read_en=0 with same addresses -> both outputs 16'h0000 while storage keeps its values; raise read_en again -> CCCC/AAAA return.
- Assert reset between clock edges -> all four entries read 16'h0000 immediately; write_en=1, write_data=16'h1234 during reset -> entry stays 0.
- reset=0, write_en=1, write_adr=2, write_data=16'hFFFF, one rising edge; then write_en=0, read_en=1, read_adr1=2 -> read_data1=16'hFFFF; other entries unchanged (0 after reset).
- read_adr1=read_adr2=3, write_adr=3, write_data=16'h5A5A, write_en=1 -> both ports show old value before edge, 16'h5A5A right after edge.
- Back-to-back writes: 16'h0001 to reg0, 16'h0002 to reg1, 16'h0003 to reg2, 16'h0004 to reg3 on four consecutive edges -> read (0,1)=0001/0002, (2,3)=0003/0004.

Source files
------------

// File: rtl/register_file.sv
// 4 x 16-bit register file: two combinational read ports, one synchronous write port.
// Reads are zero-latency and gated by read_en; writes land on the rising clk edge.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] write_adr,
  input  logic [ADDR_WIDTH-1:0] read_adr1,
  input  logic [ADDR_WIDTH-1:0] read_adr2,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] reg_file [0:DEPTH-1];

  // Reset wins over write_en and keeps every entry cleared while it stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_file[i] <= '0;
      end
    end else if (write_en) begin
      reg_file[write_adr] <= write_data;
    end
  end

  // No write-through bypass: a same-address read shows the old value until the edge.
  assign read_data1 = read_en ? reg_file[read_adr1] : '0;
  assign read_data2 = read_en ? reg_file[read_adr2] : '0;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with hand-computed expected values.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic        read_en;
  logic [1:0]  write_adr;
  logic [1:0]  read_adr1;
  logic [1:0]  read_adr2;
  logic [15:0] write_data;
  logic [15:0] read_data1;
  logic [15:0] read_data2;

  int errors = 0;
  int checks = 0;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .read_en    (read_en),
    .write_adr  (write_adr),
    .read_adr1  (read_adr1),
    .read_adr2  (read_adr2),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_pair(input logic [1:0] a1, input logic [1:0] a2,
                           input logic [15:0] e1, input logic [15:0] e2, input string tag);
    read_adr1 = a1;
    read_adr2 = a2;
    #1;
    check_val({tag, "_p1"}, read_data1, e1);
    check_val({tag, "_p2"}, read_data2, e2);
  endtask

  initial begin
    reset      = 1'b1;
    write_en   = 1'b0;
    read_en    = 1'b1;
    write_adr  = 2'd0;
    read_adr1  = 2'd0;
    read_adr2  = 2'd1;
    write_data = 16'h0000;
    #2;
    read_pair(2'd0, 2'd1, 16'h0000, 16'h0000, "rst_01");
    read_pair(2'd2, 2'd3, 16'h0000, 16'h0000, "rst_23");

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Backdoor preload; non-blocking to match how the design drives the array.
    dut.reg_file[0] <= 16'hCCCC;
    dut.reg_file[1] <= 16'hAAAA;
    dut.reg_file[2] <= 16'hF0F0;
    dut.reg_file[3] <= 16'h8E38;
    #1;
    read_pair(2'd0, 2'd1, 16'hCCCC, 16'hAAAA, "pre_01");
    read_pair(2'd2, 2'd3, 16'hF0F0, 16'h8E38, "pre_23");

    read_en = 1'b0;
    read_pair(2'd0, 2'd1, 16'h0000, 16'h0000, "ren0");
    read_en = 1'b1;
    read_pair(2'd0, 2'd1, 16'hCCCC, 16'hAAAA, "ren1");

    // Asynchronous reset between clock edges, with a write attempted during it.
    @(negedge clk);
    #1;
    reset = 1'b1;
    read_pair(2'd0, 2'd1, 16'h0000, 16'h0000, "arst_01");
    read_pair(2'd2, 2'd3, 16'h0000, 16'h0000, "arst_23");
    write_en   = 1'b1;
    write_adr  = 2'd0;
    write_data = 16'h1234;
    @(posedge clk);
    #1;
    read_pair(2'd0, 2'd1, 16'h0000, 16'h0000, "rst_nowr");
    @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b0;

    @(negedge clk);
    write_en   = 1'b1;
    write_adr  = 2'd2;
    write_data = 16'hFFFF;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_pair(2'd2, 2'd0, 16'hFFFF, 16'h0000, "wr2_20");
    read_pair(2'd1, 2'd3, 16'h0000, 16'h0000, "wr2_13");

    // Same-address read during write: old value before the edge, new after.
    @(negedge clk);
    write_en   = 1'b1;
    write_adr  = 2'd3;
    write_data = 16'h5A5A;
    read_pair(2'd3, 2'd3, 16'h0000, 16'h0000, "raw_old");
    @(posedge clk);
    #1;
    check_val("raw_new_p1", read_data1, 16'h5A5A);
    check_val("raw_new_p2", read_data2, 16'h5A5A);

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      write_en   = 1'b1;
      write_adr  = 2'(i);
      write_data = 16'(i + 1);
      @(posedge clk);
      #1;
    end
    write_en = 1'b0;
    read_pair(2'd0, 2'd1, 16'h0001, 16'h0002, "b2b_01");
    read_pair(2'd2, 2'd3, 16'h0003, 16'h0004, "b2b_23");

    // Writes proceed with read_en low.
    @(negedge clk);
    read_en    = 1'b0;
    write_en   = 1'b1;
    write_adr  = 2'd1;
    write_data = 16'hBEEF;
    read_pair(2'd1, 2'd0, 16'h0000, 16'h0000, "ren0_wr");
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b1;
    read_pair(2'd1, 2'd0, 16'hBEEF, 16'h0001, "ren0_wr_rd");

    // Mid-operation reset drops outputs without a clock edge.
    read_pair(2'd2, 2'd3, 16'h0003, 16'h0004, "pre_mid");
    reset = 1'b1;
    #1;
    check_val("mid_rst_p1", read_data1, 16'h0000);
    check_val("mid_rst_p2", read_data2, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
